// File: rtl/gene_segment_loader.sv
// gene_segment_loader
// ---------------------------------------------------------------------------
// Reads one gene from a bank of gene memory and cuts it into overlapping
// segments, one per processing unit. Each segment carries ELEMENT_COUNT new
// elements plus CODON_MAX_LENGTH-1 trailing overlap elements, so a codon that
// straddles a segment boundary is always seen whole by one unit. Segments are
// handed downstream over a valid/ready handshake.
//
// Optional build feature (macro GENE_SEGMENT_LOADER_OVERLAP_REUSE_EN):
//   when defined, segments after the first reuse their overlap elements from
//   the tail of the previous segment instead of re-reading them, which
//   shortens each turnaround by CODON_MAX_LENGTH-1 cycles. Segment contents
//   are identical in both builds.
//
// Ports
//   CLK          clock, rising edge
//   RST_N        asynchronous active-low reset
//   start        pulse, begins a gene load (honoured only when idle)
//   gene_sel     bank to load, latched with start
//   busy         high while a load is in progress (through the done cycle)
//   done         one-cycle pulse after the last segment handshake
//   mem_rd_en    gene memory read strobe
//   mem_sel      gene memory bank select (latched gene_sel)
//   mem_addr     gene memory element address
//   mem_rd_data  gene memory read data, valid one cycle after mem_rd_en
//   seg_valid    a complete segment is presented
//   seg_ready    downstream accepts the segment
//   seg_data     packed segment, element 0 in the least significant bits
//   seg_idx      index of the presented segment (target processing unit)
// ---------------------------------------------------------------------------
module gene_segment_loader #(
  parameter int ELEMENT_SIZE     = 4,
  parameter int CODON_MAX_LENGTH = 5,
  parameter int ELEMENT_COUNT    = 32,
  parameter int GENE_MEM_DEPTH   = 256,
  parameter int GENE_MEM_COUNT   = 2,
  parameter logic [ELEMENT_SIZE-1:0] PAD_VALUE = '0,
  localparam int SEGMENT_SIZE    = ELEMENT_COUNT + CODON_MAX_LENGTH - 1,
  localparam int PROC_UNIT_COUNT = GENE_MEM_DEPTH / ELEMENT_COUNT,
  localparam int SEL_W  = (GENE_MEM_COUNT > 1) ? $clog2(GENE_MEM_COUNT) : 1,
  localparam int ADDR_W = $clog2(GENE_MEM_DEPTH),
  localparam int IDX_W  = (PROC_UNIT_COUNT > 1) ? $clog2(PROC_UNIT_COUNT) : 1
) (
  input  logic                                 CLK,
  input  logic                                 RST_N,
  input  logic                                 start,
  input  logic [SEL_W-1:0]                     gene_sel,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 mem_rd_en,
  output logic [SEL_W-1:0]                     mem_sel,
  output logic [ADDR_W-1:0]                    mem_addr,
  input  logic [ELEMENT_SIZE-1:0]              mem_rd_data,
  output logic                                 seg_valid,
  input  logic                                 seg_ready,
  output logic [SEGMENT_SIZE*ELEMENT_SIZE-1:0] seg_data,
  output logic [IDX_W-1:0]                     seg_idx
);

  // Position within a segment and full-range element address. The address
  // needs one extra bit because the last segment's overlap runs past the end
  // of the bank and must be recognised as padding rather than wrapping.
  localparam int POS_W  = $clog2(SEGMENT_SIZE);
  localparam int FULL_W = ADDR_W + 1;
  localparam int SEG_W  = SEGMENT_SIZE * ELEMENT_SIZE;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    DRAIN,
    OUT,
    DONE
  } state_t;

  state_t               state;
  state_t               state_nxt;

  logic [IDX_W-1:0]     k;
  logic [POS_W-1:0]     j;
  logic [SEL_W-1:0]     sel;
  logic [FULL_W-1:0]    full_addr;
  logic                 in_range;
  logic                 last_issue;
  logic                 last_seg;
  logic                 handshake;

  logic                 vld_p1;
  logic [POS_W-1:0]     idx_p1;
  logic                 pad_p1;
  logic [SEG_W-1:0]     seg_reg;

  function automatic logic [FULL_W-1:0] element_addr(
    input logic [IDX_W-1:0] seg,
    input logic [POS_W-1:0] pos
  );
    return FULL_W'(seg) * FULL_W'(ELEMENT_COUNT) + FULL_W'(pos);
  endfunction

  function automatic logic [ELEMENT_SIZE-1:0] capture_element(
    input logic                    pad,
    input logic [ELEMENT_SIZE-1:0] data
  );
    return pad ? PAD_VALUE : data;
  endfunction

  assign full_addr  = element_addr(k, j);
  assign in_range   = (full_addr < FULL_W'(GENE_MEM_DEPTH));
  assign last_issue = (j == POS_W'(SEGMENT_SIZE - 1));
  assign last_seg   = (k == IDX_W'(PROC_UNIT_COUNT - 1));
  assign handshake  = (state == OUT) && seg_ready;

  assign mem_sel  = sel;
  assign seg_idx  = k;
  assign seg_data = seg_reg;

  // Control FSM: state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Control FSM: next state and state-decoded outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    seg_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FILL;
        end
      end
      FILL: begin
        busy = 1'b1;
        // Out-of-range addresses still take their cycle but skip the read;
        // the capture stage substitutes the pad value.
        mem_rd_en = in_range;
        mem_addr  = in_range ? full_addr[ADDR_W-1:0] : '0;
        if (last_issue) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        busy      = 1'b1;
        state_nxt = OUT;
      end
      OUT: begin
        busy      = 1'b1;
        seg_valid = 1'b1;
        if (seg_ready) begin
          state_nxt = last_seg ? DONE : FILL;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Segment counter, element position and latched bank
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      k   <= '0;
      j   <= '0;
      sel <= '0;
    end else if ((state == IDLE) && start) begin
      sel <= gene_sel;
      k   <= '0;
      j   <= '0;
    end else if ((state == FILL) && !last_issue) begin
      j <= j + POS_W'(1);
    end else if (handshake && !last_seg) begin
      k <= k + IDX_W'(1);
`ifdef GENE_SEGMENT_LOADER_OVERLAP_REUSE_EN
      // The overlap elements are carried over, so reading resumes just
      // past them.
      j <= POS_W'(CODON_MAX_LENGTH - 1);
`else
      j <= '0;
`endif
    end
  end

  // ---- stage p1: read issued, data returns next cycle ----
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= (state == FILL);
    end
  end

  always_ff @(posedge CLK) begin
    idx_p1 <= j;
    pad_p1 <= !in_range;
  end

  // ---- stage p2: element written into the segment register ----
`ifdef GENE_SEGMENT_LOADER_OVERLAP_REUSE_EN
  localparam int OVL_W = (CODON_MAX_LENGTH - 1) * ELEMENT_SIZE;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      seg_reg <= '0;
    end else if (vld_p1) begin
      for (int e = 0; e < SEGMENT_SIZE; e++) begin
        if (idx_p1 == POS_W'(e)) begin
          seg_reg[e*ELEMENT_SIZE +: ELEMENT_SIZE] <= capture_element(pad_p1, mem_rd_data);
        end
      end
    end
`ifdef GENE_SEGMENT_LOADER_OVERLAP_REUSE_EN
    else if (handshake && !last_seg) begin
      // The tail of the accepted segment is the head of the next one.
      seg_reg[OVL_W-1:0] <= seg_reg[SEG_W-1 -: OVL_W];
    end
`endif
  end

endmodule

// File: tb/tb_gene_segment_loader.sv
// Testbench for gene_segment_loader: a table of load scenarios drives the
// loader against a two-bank gene memory model; expected segments are queued
// when a load starts and compared as the loader hands them over.
module tb_gene_segment_loader;

  localparam int ES    = 4;
  localparam int CML   = 5;
  localparam int EC    = 32;
  localparam int SS    = EC + CML - 1;
  localparam int DEPTH = 256;
  localparam int PUC   = DEPTH / EC;
  localparam int SEGW  = SS * ES;
`ifdef GENE_SEGMENT_LOADER_OVERLAP_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic            start = 1'b0;
  logic            gene_sel = 1'b0;
  logic            busy;
  logic            done;
  logic            mem_rd_en;
  logic            mem_sel;
  logic [7:0]      mem_addr;
  logic [3:0]      mem_rd_data;
  logic            seg_valid;
  logic            seg_ready = 1'b0;
  logic [SEGW-1:0] seg_data;
  logic [2:0]      seg_idx;

  gene_segment_loader dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .start(start),
    .gene_sel(gene_sel),
    .busy(busy),
    .done(done),
    .mem_rd_en(mem_rd_en),
    .mem_sel(mem_sel),
    .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data),
    .seg_valid(seg_valid),
    .seg_ready(seg_ready),
    .seg_data(seg_data),
    .seg_idx(seg_idx)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Gene memory model: registered read, data one cycle after the strobe.
  logic [3:0] mem [2][DEPTH];
  logic [3:0] rd_q = 4'h0;
  always @(posedge CLK) if (mem_rd_en) rd_q <= mem[mem_sel][mem_addr];
  assign mem_rd_data = rd_q;

  typedef struct {
    int              idx;
    logic [SEGW-1:0] data;
  } seg_t;
  seg_t q[$];

  typedef struct {
    int bank;
    int pattern;    // 0: a mod 16, 1: all 0xA, 2: random
    int stall_seg;  // segment to hold off, -1 for none
    int stall_len;
    int poke_at;    // cycles after start for a stray start/gene_sel toggle, 0 for none
    int exp_sel;
    int exp_segs;
  } rec_t;

  int checks = 0;
  int errors = 0;
  int ref_cyc = 0;
  int last_hs = -10;
  int last_idx = -1;
  int rd_cnt = 0;
  int seg_cnt = 0;
  int done_cnt = 0;
  int exp_sel = 0;
  bit prev_valid = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_data(input string name, input logic [SEGW-1:0] act, input logic [SEGW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic int read_base(input int idx);
    return EC * idx + ((REUSE && idx > 0) ? CML - 1 : 0);
  endfunction

  function automatic int exp_reads(input int idx);
    int n = 0;
    for (int a = read_base(idx); a <= EC * idx + SS - 1; a++) if (a < DEPTH) n++;
    return n;
  endfunction

  function automatic int exp_gap(input int idx);
    if (idx == 0) return SS + 2;
    return REUSE ? EC + 2 : SS + 2;
  endfunction

  task automatic push_expected(input int bank);
    seg_t s;
    for (int k = 0; k < PUC; k++) begin
      s.idx  = k;
      s.data = '0;
      for (int j = 0; j < SS; j++) begin
        int a = EC * k + j;
        s.data[j*ES +: ES] = (a < DEPTH) ? mem[bank][a] : 4'h0;
      end
      q.push_back(s);
    end
  endtask

  task automatic fill_bank(input int bank, input int pattern);
    for (int a = 0; a < DEPTH; a++) begin
      case (pattern)
        0:       mem[bank][a] = 4'(a % 16);
        1:       mem[bank][a] = 4'hA;
        default: mem[bank][a] = 4'($urandom_range(0, 15));
      endcase
    end
  endtask

  // Monitor / scoreboard
  always @(negedge CLK) begin
    if (!RST_N) begin
      rd_cnt     = 0;
      prev_valid = 1'b0;
    end else begin
      if (mem_rd_en) begin
        if (q.size() == 0) begin
          chk("rd_while_idle", 1, 0);
        end else begin
          chk("rd_addr", int'(mem_addr), read_base(q[0].idx) + rd_cnt);
          chk("rd_sel", int'(mem_sel), exp_sel);
        end
        rd_cnt++;
      end
      if (seg_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_seg", 1, 0);
        end else begin
          if (!prev_valid) chk("seg_latency", cyc - ref_cyc, exp_gap(q[0].idx));
          chk("seg_idx", int'(seg_idx), q[0].idx);
          chk_data("seg_data", seg_data, q[0].data);
          chk("no_rd_while_valid", int'(mem_rd_en), 0);
          if (seg_ready) begin
            chk("rd_count", rd_cnt, exp_reads(q[0].idx));
            rd_cnt   = 0;
            ref_cyc  = cyc;
            last_hs  = cyc;
            last_idx = q[0].idx;
            void'(q.pop_front());
            seg_cnt++;
          end
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_timing", cyc - last_hs, 1);
        chk("done_last_seg", last_idx, PUC - 1);
      end
      prev_valid = seg_valid && !seg_ready;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_rd_en"}, int'(mem_rd_en), 0);
    chk({tag, "_addr"}, int'(mem_addr), 0);
    chk({tag, "_sel"}, int'(mem_sel), 0);
    chk({tag, "_valid"}, int'(seg_valid), 0);
    chk_data({tag, "_data"}, seg_data, '0);
    chk({tag, "_idx"}, int'(seg_idx), 0);
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #3;
    RST_N = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    q.delete();
    start = 1'b0;
    repeat (2) @(posedge CLK);
    #3;
    RST_N = 1'b1;
  endtask

  task automatic run_load(input rec_t r);
    int  stall_left = r.stall_len;
    int  done_b = done_cnt;
    int  seg_b = seg_cnt;
    bit  finished = 1'b0;
    int  t0;
    fill_bank(r.bank, r.pattern);
    exp_sel = r.exp_sel;
    push_expected(r.bank);
    @(posedge CLK);
    #1;
    gene_sel  = r.bank[0];
    start     = 1'b1;
    seg_ready = 1'b1;
    ref_cyc   = cyc;
    t0        = cyc;
    @(posedge CLK);
    #1;
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    for (int n = 0; n < 1500 && !finished; n++) begin
      if (done) begin
        finished = 1'b1;
      end else begin
        if (r.poke_at > 0 && cyc == t0 + r.poke_at) begin
          gene_sel = ~gene_sel;
          start    = 1'b1;
        end else begin
          start = 1'b0;
        end
        if (seg_valid && int'(seg_idx) == r.stall_seg && stall_left > 0) begin
          seg_ready = 1'b0;
          stall_left--;
        end else begin
          seg_ready = 1'b1;
        end
        @(posedge CLK);
        #1;
      end
    end
    start = 1'b0;
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL load_timeout: no done within budget, bank %0d", r.bank);
      do_reset();
    end else begin
      @(posedge CLK);
      #1;
      chk("busy_after_done", int'(busy), 0);
      chk("done_single", int'(done), 0);
      chk("done_count", done_cnt - done_b, 1);
      chk("seg_count", seg_cnt - seg_b, r.exp_segs);
      chk("queue_drained", q.size(), 0);
    end
  endtask

  rec_t tab[5];

  initial begin
    tab[0] = '{bank: 0, pattern: 0, stall_seg: -1, stall_len: 0,  poke_at: 0,   exp_sel: 0, exp_segs: 8};
    tab[1] = '{bank: 0, pattern: 0, stall_seg: 2,  stall_len: 10, poke_at: 0,   exp_sel: 0, exp_segs: 8};
    tab[2] = '{bank: 1, pattern: 1, stall_seg: -1, stall_len: 0,  poke_at: 50,  exp_sel: 1, exp_segs: 8};
    tab[3] = '{bank: 0, pattern: 2, stall_seg: 7,  stall_len: 3,  poke_at: 0,   exp_sel: 0, exp_segs: 8};
    tab[4] = '{bank: 1, pattern: 2, stall_seg: 0,  stall_len: 5,  poke_at: 120, exp_sel: 1, exp_segs: 8};

    fill_bank(0, 0);
    fill_bank(1, 1);
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs("reset");
    #2;
    RST_N = 1'b1;
    repeat (2) @(posedge CLK);

    for (int i = 0; i < 5; i++) run_load(tab[i]);

    // Abort a load during the fill of segment 4, then restart cleanly.
    begin
      bit hit = 1'b0;
      int done_b;
      fill_bank(0, 0);
      exp_sel = 0;
      push_expected(0);
      @(posedge CLK);
      #1;
      gene_sel  = 1'b0;
      start     = 1'b1;
      seg_ready = 1'b1;
      ref_cyc   = cyc;
      done_b    = done_cnt;
      @(posedge CLK);
      #1;
      start = 1'b0;
      for (int n = 0; n < 1000 && !hit; n++) begin
        @(posedge CLK);
        #1;
        if (seg_idx == 3'd4 && busy && !seg_valid) hit = 1'b1;
      end
      if (!hit) begin
        checks++;
        errors++;
        $display("FAIL reach_seg4: segment 4 fill never observed");
      end
      repeat (4) @(posedge CLK);
      #1;
      chk("pre_reset_reading", int'(mem_rd_en), 1);
      do_reset();
      chk("no_done_on_abort", done_cnt - done_b, 0);
      repeat (2) @(posedge CLK);
      run_load(tab[0]);
    end

    repeat (3) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
